ps2_key_dispatcher: RTL
=======================

PS2_KEY_DISPATCHER -- requirements
Module: ps2_key_dispatcher

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the output character queue depth; legal values are powers of two from 2 to 16.
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 key  input  16  SHALL carry the scan code from ps2_rx: {8'h00,code} for one-byte keys, {8'hE0,code} for extended keys.
REQ-005 key_pressed  input  1  SHALL be 1 for a make event and 0 for a break event; it is qualified by new_key.
REQ-006 new_key  input  1  SHALL be a one-cycle strobe marking a valid key/key_pressed pair.
REQ-007 char_data  output  8  SHALL carry the ASCII character at the queue head.
REQ-008 char_valid  output  1  SHALL be high when the queue is not empty.
REQ-009 char_ready  input  1  SHALL be the consumer accept; a pop occurs when char_valid and char_ready are both high in a cycle.
REQ-010 shift_held  output  1  SHALL be high while either shift key is held.
REQ-011 overflow  output  1  SHALL pulse for one cycle when a translated character is dropped.

Function
REQ-012 The block SHALL evaluate inputs only in cycles where new_key=1 and ignore key and key_pressed otherwise.
REQ-013 The block SHALL keep lshift and rshift flags: 0x0012 sets or clears lshift, 0x0059 sets or clears rshift, per key_pressed; shift_held = lshift|rshift.
REQ-014 Shift events SHALL never enqueue a character.
REQ-015 The block SHALL hold a held_key register: on a make of a non-shift key, a make equal to held_key is a typematic repeat and SHALL be dropped silently.
REQ-016 Any other non-shift make SHALL be translated and SHALL load held_key.
REQ-017 A break equal to held_key SHALL clear held_key to 0.
REQ-018 Breaks of other non-shift keys SHALL be ignored and SHALL enqueue nothing.
REQ-019 Unshifted translation SHALL be:
- 0x45..'0', 0x16..'1', 0x1E..'2', 0x26..'3', 0x25..'4', 0x2E..'5', 0x36..'6', 0x3D..'7', 0x3E..'8', 0x46..'9'
- 0x22..'x', 0x4E..'-', 0x4A..'/', 0xE04A..'/', 0x49..'.'
- 0x5A..0x0A, 0xE05A..0x0A, 0x66..0x08
REQ-020 Shifted translation SHALL be: 0x55..'+', 0x3E..'*', 0x46..'(', 0x45..')', 0x36..'^'.
REQ-021 With shift held, any other code SHALL use its unshifted translation.
REQ-022 Unlisted codes SHALL produce no character; held_key SHALL still be updated for them.
REQ-023 Translation SHALL be registered: a character SHALL be pushed to the queue exactly 1 cycle after its new_key cycle, and char_valid SHALL rise at the earliest on the cycle after the push.
REQ-024 The queue SHALL be a FIFO_DEPTH-entry circular buffer with wrapping read and write pointers and a count of width log2(FIFO_DEPTH)+1.
REQ-025 The queue SHALL preserve event order.
REQ-026 char_data SHALL be stable while char_valid=1 and char_ready=0.
REQ-027 A push when full SHALL be dropped and SHALL assert overflow for 1 cycle, unless a pop occurs in the same cycle, in which case the push SHALL succeed.
REQ-028 A simultaneous push and pop on an empty queue is impossible, since char_valid=0; on a non-empty queue it SHALL leave count unchanged.
REQ-029 A pop when empty SHALL have no effect.

Reset
REQ-030 While rst_n=0 the block SHALL asynchronously clear queue pointers and count, lshift, rshift, held_key, and the translation stage.
REQ-031 During reset the outputs SHALL be char_valid=0, char_data=0, shift_held=0, overflow=0.
REQ-032 A new_key strobe coincident with reset deassertion SHALL be ignored.
REQ-033 A reset mid-stream SHALL discard all queued and in-flight characters.

Verification
REQ-034 Make 0x0016 then break 0x0016 with char_ready=1 -> exactly one char 0x31; char_valid rises 2 cycles after new_key.
REQ-035 Make 0x0012, make 0x0055, break 0x0055, break 0x0012, make 0x0055 -> chars '+' (0x2B) then '=' is not emitted (0x55 unshifted is unlisted), and shift_held goes 1 then 0.
REQ-036 Make 0x0026 three times without a break, then break, then make 0x0026 -> exactly two '3' (0x33) characters.
REQ-037 With char_ready=0, send FIFO_DEPTH+1 distinct digit makes -> queue holds the first 4 in order and overflow pulses once; then drain to 0 entries and char_valid=0.
REQ-038 Queue full with char_ready=1 held and a push arriving in the same cycle as a pop -> no overflow and count stays at FIFO_DEPTH.
REQ-039 Make 0xE05A, then assert rst_n=0 for 1 cycle before the pop -> char_valid=0 and shift_held=0 after reset, and nothing is emitted afterwards.

Source files
------------

// File: rtl/ps2_key_dispatcher.sv
// ============================================================================
// ps2_key_dispatcher
//
// Turns decoded PS/2 key events into a stream of ASCII characters for a
// calculator-style keypad front end. The block tracks both shift keys and
// suppresses typematic auto-repeat of the key currently held down. It
// translates digits, operators, Enter and Backspace, and buffers the
// resulting characters in a small FIFO with a valid/ready handshake.
//
// Parameters
//   FIFO_DEPTH  : character queue depth, power of two from 2 to 16
//
// Ports
//   clk         in   1   system clock, all state updates on the rising edge
//   rst_n       in   1   asynchronous active-low reset
//   key         in  16   scan code, {8'h00,code} or {8'hE0,code} for extended
//   key_pressed in   1   1 = make, 0 = break (qualified by new_key)
//   new_key     in   1   one-cycle strobe marking a valid key/key_pressed pair
//   char_data   out  8   ASCII character at the queue head (0 when empty)
//   char_valid  out  1   queue not empty
//   char_ready  in   1   consumer accept, pop on char_valid & char_ready
//   shift_held  out  1   either shift key currently held
//   overflow    out  1   one-cycle pulse when a translated character is lost
// ============================================================================
module ps2_key_dispatcher #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] key,
    input  logic        key_pressed,
    input  logic        new_key,
    output logic [7:0]  char_data,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        shift_held,
    output logic        overflow
);

    localparam int              AW         = $clog2(FIFO_DEPTH);
    localparam int              CW         = AW + 1;
    localparam logic [CW-1:0]   FULL_COUNT = CW'(FIFO_DEPTH);

    localparam logic [15:0]     KEY_LSHIFT = 16'h0012;
    localparam logic [15:0]     KEY_RSHIFT = 16'h0059;

    // ------------------------------------------------------------------
    // Key-event state
    // ------------------------------------------------------------------
    logic        armed;
    logic        lshift;
    logic        rshift;
    logic [15:0] held_key;

    logic        key_event;
    logic        is_shift_key;
    logic        is_repeat;
    logic        accept_make;
    logic        clear_held;

    // ------------------------------------------------------------------
    // Translation
    // ------------------------------------------------------------------
    logic        plain_hit;
    logic [7:0]  plain_char;
    logic        shifted_hit;
    logic [7:0]  shifted_char;
    logic        xlat_hit;
    logic [7:0]  xlat_char;

    logic        push_pending;
    logic [7:0]  push_char;

    // ------------------------------------------------------------------
    // Character queue
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          fifo_empty;
    logic          fifo_full;
    logic          do_pop;
    logic          do_push;

    // ------------------------------------------------------------------
    // Event qualification. The armed flag stays low for the first edge
    // after reset release, so a strobe that arrives together with the
    // release is ignored rather than racing the reset removal.
    // ------------------------------------------------------------------
    always_comb begin
        key_event    = new_key & armed;
        is_shift_key = (key == KEY_LSHIFT) || (key == KEY_RSHIFT);
        is_repeat    = (key == held_key);
        accept_make  = key_event & ~is_shift_key & key_pressed & ~is_repeat;
        clear_held   = key_event & ~is_shift_key & ~key_pressed & is_repeat;
    end

    assign shift_held = lshift | rshift;

    // ------------------------------------------------------------------
    // Unshifted translation table. Enter and keypad '/' exist in both
    // the plain and the E0-extended code pages, so both are listed.
    // ------------------------------------------------------------------
    always_comb begin
        plain_hit  = 1'b1;
        plain_char = 8'h00;
        case (key)
            16'h0045: plain_char = 8'h30;
            16'h0016: plain_char = 8'h31;
            16'h001E: plain_char = 8'h32;
            16'h0026: plain_char = 8'h33;
            16'h0025: plain_char = 8'h34;
            16'h002E: plain_char = 8'h35;
            16'h0036: plain_char = 8'h36;
            16'h003D: plain_char = 8'h37;
            16'h003E: plain_char = 8'h38;
            16'h0046: plain_char = 8'h39;
            16'h0022: plain_char = 8'h78;
            16'h004E: plain_char = 8'h2D;
            16'h004A: plain_char = 8'h2F;
            16'hE04A: plain_char = 8'h2F;
            16'h0049: plain_char = 8'h2E;
            16'h005A: plain_char = 8'h0A;
            16'hE05A: plain_char = 8'h0A;
            16'h0066: plain_char = 8'h08;
            default:  plain_hit  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Shifted translation table. Only these five codes change meaning
    // with shift; every other code falls back to the plain table, which
    // is why 0x55 is only ever '+' and never '='.
    // ------------------------------------------------------------------
    always_comb begin
        shifted_hit  = 1'b1;
        shifted_char = 8'h00;
        case (key)
            16'h0055: shifted_char = 8'h2B;
            16'h003E: shifted_char = 8'h2A;
            16'h0046: shifted_char = 8'h28;
            16'h0045: shifted_char = 8'h29;
            16'h0036: shifted_char = 8'h5E;
            default:  shifted_hit  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Select between the two tables using the shift state that was in
    // effect before this event.
    // ------------------------------------------------------------------
    always_comb begin
        if (shift_held && shifted_hit) begin
            xlat_hit  = 1'b1;
            xlat_char = shifted_char;
        end else begin
            xlat_hit  = plain_hit;
            xlat_char = plain_char;
        end
    end

    // ------------------------------------------------------------------
    // Reset-release arming flop.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Shift flags follow make/break of the two shift keys directly.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lshift <= 1'b0;
            rshift <= 1'b0;
        end else if (key_event) begin
            if (key == KEY_LSHIFT) begin
                lshift <= key_pressed;
            end
            if (key == KEY_RSHIFT) begin
                rshift <= key_pressed;
            end
        end
    end

    // ------------------------------------------------------------------
    // held_key remembers the last accepted non-shift make so typematic
    // repeats can be dropped. Unlisted codes still load it, so a repeat
    // of an unlisted key cannot slip a later listed key's repeat through.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_key <= 16'h0000;
        end else if (accept_make) begin
            held_key <= key;
        end else if (clear_held) begin
            held_key <= 16'h0000;
        end
    end

    // ------------------------------------------------------------------
    // Registered translation stage: the character computed in the
    // new_key cycle is offered to the queue in the following cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_pending <= 1'b0;
            push_char    <= 8'h00;
        end else begin
            push_pending <= accept_make & xlat_hit;
            if (accept_make && xlat_hit) begin
                push_char <= xlat_char;
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue handshake. A push into a full queue still succeeds when a
    // pop frees a slot in the same cycle; otherwise it is dropped and
    // flagged on overflow for that single cycle.
    // ------------------------------------------------------------------
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == FULL_COUNT);
        char_valid = ~fifo_empty;
        do_pop     = char_valid & char_ready;
        do_push    = push_pending & (~fifo_full | do_pop);
        overflow   = push_pending & fifo_full & ~do_pop;
        char_data  = fifo_empty ? 8'h00 : mem[rd_ptr];
    end

    // ------------------------------------------------------------------
    // Pointers wrap naturally because the depth is a power of two; the
    // extra count bit distinguishes full from empty.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage array. It needs no reset because char_data is forced to
    // zero whenever the queue is empty.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_char;
        end
    end

endmodule
